modexp_stream_ctrl: RTL and testbench

- Parametrised next-generation modular exponentiation sequencer. It computes c^d mod n by left-to-right square-and-multiply over an external Montgomery-product (MonPro) core.
- Holds operands in internal word memories and streams operand pairs to the core word by word. It captures each product, and streams the final result out with a valid/ready handshake.
- Improvements over the previous generation: generic width and depth, a runtime-selectable blinding mode, handshaked load and readout, a busy/done status, and a MonPro operation counter.

---
 rtl/modexp_stream_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_modexp_stream_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_stream_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation sequencer driving an
// external word-serial Montgomery-product core, with handshaked load and readout.
module modexp_stream_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [2:0]            load_sel,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  start,
    input  logic                  blind_en,
    output logic                  busy,
    output logic                  done,
    output logic                  mp_start,
    output logic                  mp_in_valid,
    output logic [DATA_WIDTH-1:0] mp_a,
    output logic [DATA_WIDTH-1:0] mp_b,
    input  logic                  mp_out_valid,
    input  logic [DATA_WIDTH-1:0] mp_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      mp_ops
);
    localparam int IW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TOTAL = DATA_WIDTH * NUM_WORDS;
    localparam int BW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SCAN, S_LOOP, S_POST, S_OUT} state_t;
    typedef enum logic [1:0] {MP_IDLE, MP_START, MP_SEND, MP_WAIT} mp_state_t;
    typedef enum logic [2:0] {SRC_C, SRC_T, SRC_RE, SRC_RINV, SRC_CBAR, SRC_MBAR, SRC_ONE} src_t;

    // Operand rows follow load_sel: 0=c, 1=d, 2=r, 3=t, 4=RE, 5=RINV.
    logic [DATA_WIDTH-1:0] opmem [6][NUM_WORDS];
    logic [DATA_WIDTH-1:0] cbar  [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mbar  [NUM_WORDS];
    logic [IW-1:0]         load_idx [6];

    state_t    state, state_nx;
    mp_state_t mp_state, mp_nx;
    logic              blind, loop_mul, done_r;
    logic [1:0]        step, last_step;
    logic [BW-1:0]     bit_idx;
    logic [IW-1:0]     word_idx, cap_idx, out_idx;
    logic [TOTAL-1:0]  d_flat;
    src_t              a_src, b_src;
    logic              dst_mbar, mp_go, mp_done, cap_fire, load_fire, copy_r, out_fire;
    logic [DATA_WIDTH-1:0] src_word [8];

    // Every stream transfers a word on a cycle where both valid and ready are high;
    // valid never waits on ready, and data is held stable while valid is up.
    assign load_ready  = (state == S_IDLE);
    assign load_fire   = load_valid && load_ready && (load_sel < 3'd6);
    assign busy        = (state == S_PRE) || (state == S_SCAN) || (state == S_LOOP) || (state == S_POST);
    assign done        = done_r;
    assign mp_start    = (mp_state == MP_START);
    assign mp_in_valid = (mp_state == MP_SEND);
    assign mp_a        = mp_in_valid ? src_word[a_src] : '0;
    assign mp_b        = mp_in_valid ? src_word[b_src] : '0;
    assign out_valid   = (state == S_OUT);
    assign out_data    = out_valid ? mbar[out_idx] : '0;
    assign out_fire    = out_valid && out_ready;
    assign last_step   = blind ? 2'd2 : 2'd0;
    assign mp_go       = (state == S_PRE || state == S_LOOP || state == S_POST) && (mp_state == MP_IDLE);
    assign cap_fire    = (mp_state == MP_WAIT) && mp_out_valid;
    assign mp_done     = cap_fire && (cap_idx == IW'(NUM_WORDS - 1));
    assign copy_r      = (state == S_PRE) && mp_done && (step == last_step);

    always_comb begin
        d_flat = '0;
        for (int i = 0; i < NUM_WORDS; i++) d_flat[i*DATA_WIDTH +: DATA_WIDTH] = opmem[1][i];
    end

    always_comb begin
        src_word[SRC_C]    = opmem[0][word_idx];
        src_word[SRC_T]    = opmem[3][word_idx];
        src_word[SRC_RE]   = opmem[4][word_idx];
        src_word[SRC_RINV] = opmem[5][word_idx];
        src_word[SRC_CBAR] = cbar[word_idx];
        src_word[SRC_MBAR] = mbar[word_idx];
        src_word[SRC_ONE]  = (word_idx == '0) ? DATA_WIDTH'(1) : '0;
        src_word[7]        = '0;
    end

    // Operand/destination choice is a pure function of phase, step and loop sub-step.
    always_comb begin
        a_src    = SRC_MBAR;
        b_src    = SRC_ONE;
        dst_mbar = 1'b1;
        case (state)
            S_PRE: begin
                dst_mbar = 1'b0;
                if (!blind)          begin a_src = SRC_C;    b_src = SRC_T;  end
                else if (step == 0)  begin a_src = SRC_C;    b_src = SRC_RE; end
                else                 begin a_src = SRC_CBAR; b_src = SRC_T;  end
            end
            S_LOOP: b_src = loop_mul ? SRC_CBAR : SRC_MBAR;
            S_POST: b_src = (step == 2'd0) ? SRC_ONE : (step == 2'd1) ? SRC_RINV : SRC_T;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        mp_nx    = mp_state;
        case (mp_state)
            MP_IDLE:  if (mp_go) mp_nx = MP_START;
            MP_START: mp_nx = MP_SEND;
            MP_SEND:  if (word_idx == IW'(NUM_WORDS - 1)) mp_nx = MP_WAIT;
            MP_WAIT:  if (mp_done) mp_nx = MP_IDLE;
            default:  mp_nx = MP_IDLE;
        endcase
        case (state)
            S_IDLE: if (start) state_nx = S_PRE;
            S_PRE:  if (mp_done && step == last_step) state_nx = S_SCAN;
            S_SCAN: begin
                if (d_flat[bit_idx])     state_nx = S_LOOP;
                else if (bit_idx == '0)  state_nx = S_POST;
            end
            S_LOOP: if (mp_done && (loop_mul || !d_flat[bit_idx]) && bit_idx == '0) state_nx = S_POST;
            S_POST: if (mp_done && step == last_step) state_nx = S_OUT;
            S_OUT:  if (out_fire && out_idx == IW'(NUM_WORDS - 1)) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mp_state <= MP_IDLE;
        end else begin
            state    <= state_nx;
            mp_state <= mp_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blind    <= 1'b0;
            loop_mul <= 1'b0;
            done_r   <= 1'b0;
            step     <= '0;
            bit_idx  <= '0;
            word_idx <= '0;
            cap_idx  <= '0;
            out_idx  <= '0;
            mp_ops   <= '0;
            for (int i = 0; i < 6; i++) load_idx[i] <= '0;
        end else begin
            done_r <= (state == S_POST) && (state_nx == S_OUT);
            if (load_fire)
                load_idx[load_sel] <= (load_idx[load_sel] == IW'(NUM_WORDS - 1)) ? '0 : load_idx[load_sel] + 1'b1;
            if (state == S_IDLE && start) begin
                blind    <= blind_en;
                mp_ops   <= '0;
                step     <= '0;
                loop_mul <= 1'b0;
                bit_idx  <= BW'(TOTAL - 1);
                for (int i = 0; i < 6; i++) load_idx[i] <= '0;
            end
            if (mp_state == MP_START && mp_ops != {CNT_W{1'b1}}) mp_ops <= mp_ops + 1'b1;
            if (mp_state == MP_SEND)
                word_idx <= (word_idx == IW'(NUM_WORDS - 1)) ? '0 : word_idx + 1'b1;
            if (cap_fire)
                cap_idx <= (cap_idx == IW'(NUM_WORDS - 1)) ? '0 : cap_idx + 1'b1;
            if ((state == S_PRE || state == S_POST) && mp_done)
                step <= (step == last_step) ? 2'd0 : step + 2'd1;
            if (state == S_SCAN && !d_flat[bit_idx] && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
            if (state == S_LOOP && mp_done) begin
                if (!loop_mul && d_flat[bit_idx]) begin
                    loop_mul <= 1'b1;
                end else begin
                    loop_mul <= 1'b0;
                    if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
                end
            end
            if (out_fire) out_idx <= (out_idx == IW'(NUM_WORDS - 1)) ? '0 : out_idx + 1'b1;
        end
    end

    // Operand and scratch storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_fire) opmem[load_sel][load_idx[load_sel]] <= load_data;
        if (cap_fire) begin
            if (dst_mbar) mbar[cap_idx] <= mp_out;
            else          cbar[cap_idx] <= mp_out;
        end
        if (copy_r)
            for (int i = 0; i < NUM_WORDS; i++) mbar[i] <= opmem[2][i];
    end
endmodule

// File: tb/tb_modexp_stream_ctrl.sv
// Bench for modexp_stream_ctrl: 8-bit words, 2 words, n=241, R=2^16, with a
// behavioural 5-cycle-latency MonPro responder and a result scoreboard.
module tb_modexp_stream_ctrl;
    localparam int DW = 8;
    localparam int NW = 2;
    localparam longint N = 241;

    logic          clk, reset;
    logic          load_valid, load_ready, start, blind_en, busy, done;
    logic [2:0]    load_sel;
    logic [DW-1:0] load_data, mp_a, mp_b, mp_out, out_data;
    logic          mp_start, mp_in_valid, mp_out_valid, out_valid, out_ready;
    logic [15:0]   mp_ops;

    modexp_stream_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_sel(load_sel), .load_data(load_data), .start(start), .blind_en(blind_en),
        .busy(busy), .done(done), .mp_start(mp_start), .mp_in_valid(mp_in_valid),
        .mp_a(mp_a), .mp_b(mp_b), .mp_out_valid(mp_out_valid), .mp_out(mp_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .mp_ops(mp_ops)
    );

    int n_checks = 0;
    int n_err = 0;
    int done_cnt = 0;
    longint rinv_n = 0;
    bit gap_mode = 0;
    logic [DW-1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint monpro(input longint a, input longint b);
        return (((a * b) % N) * rinv_n) % N;
    endfunction

    function automatic longint powmod(input longint c, input longint e);
        longint r = 1, b = c % N, x = e;
        while (x > 0) begin
            if (x[0]) r = (r * b) % N;
            b = (b * b) % N;
            x = x >> 1;
        end
        return r;
    endfunction

    task automatic model(input longint c, d, re, rinv, r, t, input bit blind,
                         output longint res, output int ops);
        longint cb, mb;
        int k = -1;
        if (blind) begin
            cb = monpro(c, re); cb = monpro(cb, t); cb = monpro(cb, t); ops = 3;
        end else begin
            cb = monpro(c, t); ops = 1;
        end
        mb = r;
        for (int j = 15; j >= 0; j--) if (d[j] && k < 0) k = j;
        for (int j = k; j >= 0; j--) begin
            mb = monpro(mb, mb); ops++;
            if (d[j]) begin mb = monpro(mb, cb); ops++; end
        end
        mb = monpro(mb, 1); ops++;
        if (blind) begin mb = monpro(mb, rinv); mb = monpro(mb, t); ops += 2; end
        res = mb;
    endtask

    // MonPro responder: collects NW beats, waits 5 cycles, returns NW product words.
    initial begin
        int rs = 0, cnt = 0;
        bit gap_phase = 0;
        logic [15:0] a_acc = 0, b_acc = 0, res = 0;
        mp_out_valid = 1'b0;
        mp_out = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rs = 0; mp_out_valid = 1'b0;
            end else begin
                case (rs)
                    0: begin
                        mp_out_valid = 1'b0;
                        if (mp_start) begin rs = 1; cnt = 0; end
                    end
                    1: begin
                        check_eq("mp_in_valid", mp_in_valid, 1);
                        a_acc[cnt*8 +: 8] = mp_a;
                        b_acc[cnt*8 +: 8] = mp_b;
                        cnt++;
                        if (cnt == NW) begin rs = 2; cnt = 0; end
                    end
                    2: begin
                        cnt++;
                        if (cnt == 5) begin
                            rs = 3; cnt = 0; gap_phase = 0;
                            res = 16'(monpro(longint'(a_acc), longint'(b_acc)));
                        end
                    end
                    3: begin
                        if (gap_mode && gap_phase) begin
                            mp_out_valid = 1'b0; gap_phase = 0;
                        end else begin
                            mp_out_valid = 1'b1;
                            mp_out = res[cnt*8 +: 8];
                            cnt++; gap_phase = 1;
                            if (cnt == NW) rs = 4;
                        end
                    end
                    default: begin mp_out_valid = 1'b0; rs = 0; end
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    end

    task automatic load_word(input logic [2:0] sel, input logic [DW-1:0] data);
        load_sel = sel; load_data = data; load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] c, d, r, t, re, rinv);
        logic [15:0] v[6];
        v[0] = c; v[1] = d; v[2] = r; v[3] = t; v[4] = re; v[5] = rinv;
        for (int s = 0; s < 6; s++)
            for (int w = 0; w < NW; w++) load_word(3'(s), v[s][w*8 +: 8]);
    endtask

    task automatic read_result(input bit bp);
        logic [DW-1:0] hold, e;
        bit seen;
        for (int w = 0; w < NW; w++) begin
            seen = 0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (out_valid) seen = 1; else @(negedge clk);
            end
            check_eq("out_valid_seen", seen, 1);
            if (bp) begin
                hold = out_data;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("bp_hold_data", out_data, hold);
                    check_eq("bp_hold_valid", out_valid, 1);
                end
            end
            out_ready = 1'b1;
            if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                check_eq("out_word", out_data, e);
            end
            @(negedge clk);
            out_ready = 1'b0;
        end
        check_eq("out_valid_low", out_valid, 0);
        check_eq("out_data_zero", out_data, 0);
        check_eq("sb_left", exp_q.size(), 0);
    endtask

    task automatic run(input logic [15:0] c, d, r, t, re, rinv, input bit blind, gap, bp,
                       interfere, reload, input logic [15:0] exp_res, input int exp_ops);
        bit seen = 0;
        gap_mode = gap;
        if (reload) load_all(c, d, r, t, re, rinv);
        exp_q.push_back(exp_res[7:0]);
        exp_q.push_back(exp_res[15:8]);
        done_cnt = 0;
        start = 1'b1; blind_en = blind;
        @(negedge clk);
        start = 1'b0; blind_en = 1'b0;
        check_eq("busy_rise", busy, 1);
        if (interfere) begin
            start = 1'b1; blind_en = ~blind;
            load_valid = 1'b1; load_sel = 3'd0; load_data = 8'hFF;
            repeat (3) begin
                check_eq("load_ready_busy", load_ready, 0);
                @(negedge clk);
            end
            start = 1'b0; load_valid = 1'b0; blind_en = 1'b0;
        end
        for (int i = 0; i < 20000 && !seen; i++) begin
            if (done) seen = 1; else @(negedge clk);
        end
        check_eq("done_seen", seen, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("mp_ops", mp_ops, exp_ops);
        read_result(bp);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("idle_after", load_ready, 1);
    endtask

    initial begin
        longint r, t, mres;
        int mops;
        logic [15:0] c, d, re, rinv;
        bit blind;
        for (longint x = 0; x < N; x++) if (((65536 * x) % N) == 1) rinv_n = x;
        r = 65536 % N;
        t = (r * r) % N;
        reset = 1'b1; load_valid = 0; load_sel = 0; load_data = 0; start = 0;
        blind_en = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check_eq("rst_load_ready", load_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_mp_start", mp_start, 0);
        check_eq("rst_mp_in_valid", mp_in_valid, 0);
        check_eq("rst_mp_ab", {mp_a, mp_b}, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_mp_ops", mp_ops, 0);
        reset = 1'b0;
        @(negedge clk);

        // plain run, then blinded, then d=0
        run(16'h0007, 16'h0005, 16'(r), 16'(t), 16'h1234, 16'h0056, 0, 0, 0, 0, 1, 16'h00B2, 7);
        model(7, 5, 16'h1234, 16'h0056, r, t, 1, mres, mops);
        run(16'h0007, 16'h0005, 16'(r), 16'(t), 16'h1234, 16'h0056, 1, 0, 0, 0, 1, 16'(mres), 11);
        run(16'h0007, 16'h0000, 16'(r), 16'(t), 16'h1234, 16'h0056, 0, 0, 0, 0, 1, 16'h0001, 2);
        // readout backpressure
        run(16'h0007, 16'h0005, 16'(r), 16'(t), 16'h1234, 16'h0056, 0, 0, 1, 0, 1, 16'h00B2, 7);
        // gapped product beats plus start/load while busy
        run(16'h0007, 16'h0005, 16'(r), 16'(t), 16'h1234, 16'h0056, 0, 1, 0, 1, 1, 16'h00B2, 7);

        // reset in the middle of LOOP, then restart without reloading
        start = 1'b1; blind_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && mp_ops < 3; i++) @(negedge clk);
        check_eq("reach_loop", mp_ops >= 3, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_load_ready", load_ready, 1);
        check_eq("abort_mp_ops", mp_ops, 0);
        check_eq("abort_strobes", {done, mp_start, mp_in_valid, out_valid}, 0);
        check_eq("abort_data", {mp_a, mp_b, out_data}, 0);
        reset = 1'b0;
        @(negedge clk);
        run(16'h0007, 16'h0005, 16'(r), 16'(t), 16'h1234, 16'h0056, 0, 0, 0, 0, 0, 16'h00B2, 7);

        for (int k = 0; k < 4; k++) begin
            c = 16'($urandom_range(1, 240));
            d = 16'($urandom_range(0, 65535));
            re = 16'($urandom_range(1, 240));
            rinv = 16'($urandom_range(1, 240));
            blind = 1'($urandom_range(0, 1));
            model(c, d, re, rinv, r, t, blind, mres, mops);
            if (!blind) check_eq("model_vs_pow", 32'(mres), 32'(powmod(c, d)));
            run(c, d, 16'(r), 16'(t), re, rinv, blind, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0, 1, 16'(mres), mops);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
